// File: rtl/ibex_lockstep_cmp_if.sv
// ----------------------------------------------------------------------------
// ibex_lockstep_cmp_if
// Bundles the compare traffic between the two lockstep cores and the
// comparator.
//
// Signals
//   enable_i        comparison enable
//   main_valid_i    main-core sample valid
//   main_data_i     main-core outputs, channel k in [k*ChanWidth +: ChanWidth]
//   shadow_valid_i  shadow-core sample valid
//   shadow_data_i   shadow-core outputs, same packing as main_data_i
//   chan_mask_i     per-channel compare enable (0 = channel ignored)
//   mismatch_o      registered per-channel mismatch flags
//   alert_minor_o   one-cycle pulse per mismatching compare cycle
//   alert_major_o   sticky fault indication
//   err_cnt_o       mismatch-cycle count
//   state_o         comparator state: 0 WARMUP, 1 ACTIVE, 2 FAULT
//
// Modports
//   master  side that feeds the samples and observes the results
//   slave   the comparator itself
// ----------------------------------------------------------------------------
interface ibex_lockstep_cmp_if #(
    parameter int NumChannels = 4,
    parameter int ChanWidth   = 32
);
    logic                             enable_i;
    logic                             main_valid_i;
    logic [NumChannels*ChanWidth-1:0] main_data_i;
    logic                             shadow_valid_i;
    logic [NumChannels*ChanWidth-1:0] shadow_data_i;
    logic [NumChannels-1:0]           chan_mask_i;
    logic [NumChannels-1:0]           mismatch_o;
    logic                             alert_minor_o;
    logic                             alert_major_o;
    logic [7:0]                       err_cnt_o;
    logic [1:0]                       state_o;

    modport master (
        output enable_i, main_valid_i, main_data_i,
               shadow_valid_i, shadow_data_i, chan_mask_i,
        input  mismatch_o, alert_minor_o, alert_major_o, err_cnt_o, state_o
    );

    modport slave (
        input  enable_i, main_valid_i, main_data_i,
               shadow_valid_i, shadow_data_i, chan_mask_i,
        output mismatch_o, alert_minor_o, alert_major_o, err_cnt_o, state_o
    );
endinterface

// File: rtl/ibex_lockstep_cmp.sv
// ----------------------------------------------------------------------------
// ibex_lockstep_cmp
// Lockstep comparator: the main-core sample stream is delayed by
// LockstepOffset cycles and compared channel by channel against the shadow
// core. Mismatches raise per-channel flags and a minor alert; a valid
// disagreement, or enough mismatching cycles, latches a major fault that only
// rst_i clears.
//
// Ports
//   clk_i   sole clock, rising edge
//   rst_i   synchronous active-high reset
//   bus     ibex_lockstep_cmp_if.slave (enable, main/shadow samples, channel
//           mask, mismatch flags, alerts, error count, state)
//
// Parameters
//   NumChannels     compared channels (1..16)
//   ChanWidth       bits per channel (1..64)
//   LockstepOffset  main-to-shadow delay in cycles (1..8)
//   MinorThreshold  mismatch cycles before fault (1..255), counter build only
//
// Build option
//   IBEX_LOCKSTEP_CMP_CNT_EN  defined: mismatch cycles are counted (saturating
//                             at 255) and the fault is raised when the count
//                             reaches MinorThreshold.
//                             undefined: no counter, err_cnt_o is 0 and the
//                             first mismatching cycle raises the fault.
// ----------------------------------------------------------------------------
module ibex_lockstep_cmp #(
    parameter int NumChannels    = 4,
    parameter int ChanWidth      = 32,
    parameter int LockstepOffset = 2,
    parameter int MinorThreshold = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ibex_lockstep_cmp_if.slave  bus
);

    localparam int         DataW    = NumChannels * ChanWidth;
    localparam logic [3:0] WarmLast = 4'(LockstepOffset - 1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    if (NumChannels < 1 || NumChannels > 16 || ChanWidth < 1 || ChanWidth > 64 ||
        LockstepOffset < 1 || LockstepOffset > 8 ||
        MinorThreshold < 1 || MinorThreshold > 255) begin : g_cfg_check
        $error("ibex_lockstep_cmp: parameter out of range");
    end

    function automatic logic [7:0] f_sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e                r_state;
    state_e                w_state_nxt;
    logic [3:0]            r_warm_cnt;
    logic [3:0]            w_warm_cnt_nxt;

    logic [LockstepOffset-1:0] r_dly_vld;
    logic [DataW-1:0]          r_dly_data [LockstepOffset];
    logic                      w_dly_vld;
    logic [DataW-1:0]          w_dly_data;

    logic                   w_active_en;
    logic                   w_flush;
    logic                   w_vld_err;
    logic                   w_compare;
    logic [NumChannels-1:0] w_mis_vec;
    logic                   w_any_mis;
    logic                   w_cnt_fault;

    logic [NumChannels-1:0] r_mismatch;
    logic                   r_alert_minor;

    // ---- delay line: main stream delayed by LockstepOffset cycles ----
    always_ff @(posedge clk_i) begin
        r_dly_data[0] <= bus.main_data_i;
        for (int i = 1; i < LockstepOffset; i++) begin
            r_dly_data[i] <= r_dly_data[i-1];
        end
    end

    // Leaving ACTIVE drops every in-flight sample, including the one arriving
    // this cycle, so a re-warm-up never compares stale main data.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_dly_vld <= '0;
        end else begin
            r_dly_vld[0] <= bus.main_valid_i;
            for (int i = 1; i < LockstepOffset; i++) begin
                r_dly_vld[i] <= r_dly_vld[i-1];
            end
        end
    end

    assign w_dly_vld  = r_dly_vld[LockstepOffset-1];
    assign w_dly_data = r_dly_data[LockstepOffset-1];

    // ---- compare stage ----
    assign w_active_en = (r_state == ST_ACTIVE) && bus.enable_i;
    assign w_flush     = (r_state == ST_ACTIVE) && !bus.enable_i;
    assign w_vld_err   = w_active_en && (w_dly_vld != bus.shadow_valid_i);
    assign w_compare   = w_active_en && w_dly_vld && bus.shadow_valid_i;

    always_comb begin
        w_mis_vec = '0;
        if (w_compare) begin
            for (int k = 0; k < NumChannels; k++) begin
                w_mis_vec[k] = bus.chan_mask_i[k] &&
                    (w_dly_data[k*ChanWidth +: ChanWidth] !=
                     bus.shadow_data_i[k*ChanWidth +: ChanWidth]);
            end
        end
    end

    assign w_any_mis = |w_mis_vec;

    // ---- result stage: flags visible one cycle after the compare ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mismatch    <= '0;
            r_alert_minor <= 1'b0;
        end else begin
            r_mismatch    <= w_mis_vec;
            r_alert_minor <= w_any_mis;
        end
    end

`ifdef IBEX_LOCKSTEP_CMP_CNT_EN
    localparam logic [7:0] ThreshW = 8'(MinorThreshold);

    logic [7:0] r_err_cnt;
    logic [7:0] w_err_cnt_inc;

    assign w_err_cnt_inc = f_sat_inc8(r_err_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= 8'd0;
        end else if (w_any_mis) begin
            r_err_cnt <= w_err_cnt_inc;
        end
    end

    // The fault is decided on the post-increment count so that it appears
    // together with the count that reached the threshold.
    assign w_cnt_fault = w_any_mis && (w_err_cnt_inc >= ThreshW);
`else
    assign w_cnt_fault = w_any_mis;
`endif

    // ---- FSM: state register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_WARMUP;
            r_warm_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_cnt_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        w_state_nxt    = r_state;
        w_warm_cnt_nxt = r_warm_cnt;
        case (r_state)
            ST_WARMUP: begin
                if (!bus.enable_i) begin
                    w_warm_cnt_nxt = 4'd0;
                end else if (r_warm_cnt == WarmLast) begin
                    w_state_nxt    = ST_ACTIVE;
                    w_warm_cnt_nxt = 4'd0;
                end else begin
                    w_warm_cnt_nxt = r_warm_cnt + 4'd1;
                end
            end
            ST_ACTIVE: begin
                // Dropping enable wins over any mismatch seen in the same cycle.
                if (!bus.enable_i) begin
                    w_state_nxt    = ST_WARMUP;
                    w_warm_cnt_nxt = 4'd0;
                end else if (w_vld_err || w_cnt_fault) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt    = ST_WARMUP;
                w_warm_cnt_nxt = 4'd0;
            end
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        bus.state_o       = r_state;
        bus.alert_major_o = (r_state == ST_FAULT);
        bus.mismatch_o    = r_mismatch;
        bus.alert_minor_o = r_alert_minor;
`ifdef IBEX_LOCKSTEP_CMP_CNT_EN
        bus.err_cnt_o     = r_err_cnt;
`else
        bus.err_cnt_o     = 8'd0;
`endif
    end

endmodule
